ps2_rx_fifo: RTL and testbench
==============================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter FILTER_LEN, default 8: ps2clk glitch-filter length in clk cycles, range 2..16.
REQ-002 Parameter FIFO_DEPTH, default 4: received-byte buffer depth, power of two, range 2..16.
REQ-003 Parameter TIMEOUT_CYC, default 50000: maximum clk cycles between ps2clk falling edges inside a frame (1 ms at 50 MHz).
REQ-004 Port clk, input, 1: system clock; the block uses one clock only.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port ps2clk, input, 1: raw PS/2 clock line, asynchronous to clk.
REQ-007 Port ps2data, input, 1: raw PS/2 data line, asynchronous to clk.
REQ-008 Port rx_en, input, 1: permits the start of a new frame.
REQ-009 Port rd_en, input, 1: pops the FIFO head.
REQ-010 Port dout, output, 8: FIFO head byte (show-ahead).
REQ-011 Port empty / full, output, 1 each: FIFO status flags.
REQ-012 Port count, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
REQ-013 Port frame_err, output, 1: one-cycle pulse; bad start, stop or parity bit, or timeout.
REQ-014 Port overflow, output, 1: one-cycle pulse; a good byte was dropped because the FIFO was full.

Function
REQ-015 ps2clk and ps2data each pass a 2-FF synchroniser.
REQ-016 Filter: FILTER_LEN-bit shift register of the synchronised ps2clk; the filtered clock goes 1 on all-ones and 0 on all-zeros, else holds.
REQ-017 A falling edge is filtered clock 1 in the previous cycle and 0 in the current cycle; ps2data is sampled on that cycle.
REQ-018 FSM states: IDLE, SHIFT, CHECK.
- IDLE -> SHIFT on falling edge with rx_en=1; start bit captured; bit counter = 10.
- SHIFT: each falling edge shifts in one bit and decrements the counter; the edge that captures the 11th bit (stop) -> CHECK.
- CHECK -> IDLE unconditionally after 1 cycle.
REQ-019 Frame bit order: start, D0..D7 (LSB first), parity, stop.
REQ-020 CHECK: good = start==0, stop==1, and ^{D,parity}==1 (odd parity); a good frame pushes D; a bad frame pulses frame_err and is not pushed.
REQ-021 Latency: push happens in the CHECK cycle; empty falls and count increments on the following clk edge.
REQ-022 Timeout: the counter clears on every falling edge and in IDLE; if it reaches TIMEOUT_CYC in SHIFT, the FSM -> IDLE, frame_err pulses, and partial data is discarded.
REQ-023 rx_en low does not abort a frame in progress; it blocks only IDLE -> SHIFT.
REQ-024 Push while full without a same-cycle pop: byte dropped, overflow pulses, FIFO contents unchanged.
REQ-025 Push and pop in the same cycle: both succeed, count unchanged, also when full.
REQ-026 rd_en while empty is ignored; count stays 0 and dout is don't-care.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; full = (count==FIFO_DEPTH).

Reset
REQ-028 reset_n low asynchronously forces: FSM=IDLE, counters=0, filter and synchronisers all-ones (line idle-high), filtered clock=1, FIFO empty.
REQ-029 Reset outputs: dout=0, empty=1, full=0, count=0, frame_err=0, overflow=0.
REQ-030 Reset mid-frame discards the partial frame; reception resumes on the first falling edge after release.

Structure
REQ-031 Shared package ps2_pkg holds the FSM state encoding, the frame length (11), and the default TIMEOUT_CYC.
REQ-032 The FIFO is one sub-module, sync_fifo (parameters WIDTH, DEPTH), reusable by the PS/2 transmit path.

Verification (50 MHz clk, 10 kHz PS/2 clock, defaults unless stated)
REQ-033 Frame 0x1C with parity 0 -> empty falls; dout=0x1C; count=1; no error pulse.
REQ-034 Frames 0xF0 (parity 1), 0x1C, 0x32 back-to-back, no pops -> three rd_en pulses yield 0xF0, 0x1C, 0x32; then empty=1.
REQ-035 Frame 0x1C with parity 1 -> frame_err pulses once; count stays 0.
REQ-036 Five good frames into FIFO_DEPTH=4 with no pops -> full=1 after the 4th; the 5th pulses overflow; contents are the first four bytes.
REQ-037 Clock stops after 5 bits -> frame_err pulses exactly 50000 cycles after the last edge; a following frame 0x1C is received correctly.
REQ-038 1-cycle ps2clk glitches (FILTER_LEN=8) mid-frame -> no extra bits shifted; byte received intact.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receive FSM encoding, frame length and default inter-edge timeout.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } ps2_state_e;

   // start + 8 data + parity + stop
   localparam int PS2_FRAME_LEN   = 11;
   localparam int PS2_TIMEOUT_DEF = 50000;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; push/pop take effect on the next edge, simultaneous push+pop always succeeds.
// A push into a full FIFO without a pop is dropped and flagged on overflow_o in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_dat_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         pop_dat_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty_o    = (cnt_q == '0);
   assign full_o     = (cnt_q == (AW+1)'(DEPTH));
   assign count_o    = cnt_q;
   assign do_push    = push_i & (~full_o | pop_i);
   assign do_pop     = pop_i & ~empty_o;
   assign overflow_o = push_i & full_o & ~pop_i;
   assign pop_dat_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchronised + glitch-filtered ps2clk, 11-bit frame capture and check, bytes buffered in sync_fifo.
// A good byte is pushed in the CHECK cycle (visible one edge later); a full FIFO drops it and pulses overflow.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = PS2_TIMEOUT_DEF
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          ps2clk,
   input  logic                          ps2data,
   input  logic                          rx_en,
   input  logic                          rd_en,
   output logic [7:0]                    dout,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          frame_err,
   output logic                          overflow
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]               clk_sync_q, data_sync_q;
   logic [FILTER_LEN-1:0]    filt_q;
   logic                     fclk_q, fclk_d, fclk_prev_q;
   logic                     fall;
   ps2_state_e               state_q, state_d;
   logic [3:0]               bitcnt_q, bitcnt_d;
   logic [PS2_FRAME_LEN-1:0] sr_q, sr_d;
   logic [TW-1:0]            tmo_q, tmo_d;
   logic                     frame_ok, push;

   // Line idles high, so everything in the clock path resets to ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         filt_q      <= '1;
         fclk_q      <= 1'b1;
         fclk_prev_q <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2clk};
         data_sync_q <= {data_sync_q[0], ps2data};
         filt_q      <= {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
         fclk_q      <= fclk_d;
         fclk_prev_q <= fclk_q;
      end
   end

   always_comb begin
      fclk_d = fclk_q;
      if (&filt_q)       fclk_d = 1'b1;
      else if (~|filt_q) fclk_d = 1'b0;
   end

   assign fall = fclk_prev_q & ~fclk_q;

   // Bits enter at the MSB, so after 11 shifts sr_q = {stop, parity, D7..D0, start}.
   assign frame_ok = ~sr_q[0] & sr_q[PS2_FRAME_LEN-1] & (^sr_q[PS2_FRAME_LEN-2:1]);

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      sr_d      = sr_q;
      tmo_d     = '0;
      push      = 1'b0;
      frame_err = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (fall && rx_en) begin
               state_d  = ST_SHIFT;
               sr_d     = {data_sync_q[1], sr_q[PS2_FRAME_LEN-1:1]};
               bitcnt_d = 4'(PS2_FRAME_LEN - 1);
            end
         end
         ST_SHIFT: begin
            if (fall) begin
               sr_d     = {data_sync_q[1], sr_q[PS2_FRAME_LEN-1:1]};
               bitcnt_d = bitcnt_q - 4'd1;
               if (bitcnt_q == 4'd1) state_d = ST_CHECK;
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               state_d   = ST_IDLE;
               frame_err = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_CHECK: begin
            state_d   = ST_IDLE;
            push      = frame_ok;
            frame_err = ~frame_ok;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         bitcnt_q <= '0;
         sr_q     <= '0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         sr_q     <= sr_d;
         tmo_q    <= tmo_d;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .push_i     (push),
      .push_dat_i (sr_q[8:1]),
      .pop_i      (rd_en),
      .pop_dat_o  (dout),
      .empty_o    (empty),
      .full_o     (full),
      .count_o    (count),
      .overflow_o (overflow)
   );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are bit-banged on ps2clk/ps2data and FIFO output is compared to hand values.
module tb_ps2_rx_fifo;
   localparam int HALF = 50;     // ps2clk half period in clk cycles
   localparam int TMO  = 2000;   // shortened timeout keeps the run short
   // Pin fall after edge E0 -> filtered fall detected in the cycle after E11 (2 sync + 8 filter + 1 reg).
   localparam int EDGE_LAT = 11;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2clk = 1'b1;
   logic       ps2data = 1'b1;
   logic       rx_en = 1'b1;
   logic       rd_en = 1'b0;
   logic [7:0] dout;
   logic       empty, full, frame_err, overflow;
   logic [2:0] count;

   int errors = 0;
   int checks = 0;
   int ferr_cnt = 0;
   int ovf_cnt = 0;
   logic e_at_check, e_after;

   ps2_rx_fifo #(.FILTER_LEN(8), .FIFO_DEPTH(4), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .ps2clk(ps2clk), .ps2data(ps2data), .rx_en(rx_en),
      .rd_en(rd_en), .dout(dout), .empty(empty), .full(full), .count(count),
      .frame_err(frame_err), .overflow(overflow)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) ferr_cnt++;
      if (overflow)  ovf_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      ps2clk = 1'b1; ps2data = 1'b1; rd_en = 1'b0; rx_en = 1'b1;
      repeat (3) step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic send_bit(input logic b);
      ps2data = b;
      repeat (HALF) step();
      ps2clk = 1'b0;
      repeat (HALF) step();
      ps2clk = 1'b1;
   endtask

   // mode: 0 plain, 1 pop during CHECK, 2 sample empty around CHECK, 3 ps2clk glitches, 4 drop rx_en after start
   task automatic send_frame(input logic [7:0] d, input logic pflip, input logic start_b,
                             input logic stop_b, input int mode);
      logic [10:0] fr;
      fr = {stop_b, ~(^d) ^ pflip, d, start_b};
      for (int i = 0; i < 11; i++) begin
         ps2data = fr[i];
         if (mode == 3 && i == 3) begin
            repeat (HALF/2) step();
            ps2clk = 1'b0; step(); ps2clk = 1'b1;
            repeat (HALF - HALF/2 - 1) step();
         end else begin
            repeat (HALF) step();
         end
         ps2clk = 1'b0;
         if (i == 10 && mode == 1) begin
            repeat (EDGE_LAT + 1) step();
            rd_en = 1'b1; step(); rd_en = 1'b0;
            repeat (HALF - EDGE_LAT - 2) step();
         end else if (i == 10 && mode == 2) begin
            repeat (EDGE_LAT + 1) step();
            e_at_check = empty; step(); e_after = empty;
            repeat (HALF - EDGE_LAT - 2) step();
         end else if (mode == 3 && i == 5) begin
            repeat (HALF/2) step();
            ps2clk = 1'b1; step(); ps2clk = 1'b0;
            repeat (HALF - HALF/2 - 1) step();
         end else begin
            repeat (HALF) step();
         end
         ps2clk = 1'b1;
         if (mode == 4 && i == 0) rx_en = 1'b0;
      end
      repeat (HALF) step();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) step();
      checks++; if (dout !== 8'h00)    begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
      checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", full); end
      checks++; if (count !== 3'd0)    begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      apply_reset();
   endtask

   task automatic test_single();
      int f0;
      f0 = ferr_cnt;
      send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 2);
      checks++; if (e_at_check !== 1'b1) begin errors++; $display("FAIL single_empty_in_check: got %b want 1", e_at_check); end
      checks++; if (e_after !== 1'b0)    begin errors++; $display("FAIL single_empty_after: got %b want 0", e_after); end
      checks++; if (dout !== 8'h1C)      begin errors++; $display("FAIL single_dout: got %h want 1c", dout); end
      checks++; if (count !== 3'd1)      begin errors++; $display("FAIL single_count: got %0d want 1", count); end
      checks++; if (ferr_cnt != f0)      begin errors++; $display("FAIL single_ferr: got %0d pulses want 0", ferr_cnt - f0); end
      pop();
      checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL single_empty_pop: got %b want 1", empty); end
      pop();  // pop while empty is ignored
      checks++; if (count !== 3'd0)      begin errors++; $display("FAIL empty_pop_count: got %0d want 0", count); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [3];
      exp[0] = 8'hF0; exp[1] = 8'h1C; exp[2] = 8'h32;
      for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b0, 1'b0, 1'b1, 0);
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL b2b_count: got %0d want 3", count); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (dout !== exp[i]) begin errors++; $display("FAIL b2b_dout%0d: got %h want %h", i, dout, exp[i]); end
         pop();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", empty); end
   endtask

   task automatic test_frame_errors();
      int f0;
      f0 = ferr_cnt;
      send_frame(8'h1C, 1'b1, 1'b0, 1'b1, 0);
      checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL parity_ferr: got %0d pulses want 1", ferr_cnt - f0); end
      checks++; if (count !== 3'd0)     begin errors++; $display("FAIL parity_count: got %0d want 0", count); end
      send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 0);
      checks++; if (ferr_cnt - f0 != 2) begin errors++; $display("FAIL start_ferr: got %0d pulses want 2", ferr_cnt - f0); end
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 0);
      checks++; if (ferr_cnt - f0 != 3) begin errors++; $display("FAIL stop_ferr: got %0d pulses want 3", ferr_cnt - f0); end
      checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL bad_frames_empty: got %b want 1", empty); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp [5];
      int o0;
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h44; exp[3] = 8'h88; exp[4] = 8'h99;
      o0 = ovf_cnt;
      for (int i = 0; i < 4; i++) send_frame(exp[i], 1'b0, 1'b0, 1'b1, 0);
      checks++; if (full !== 1'b1)      begin errors++; $display("FAIL ovf_full4: got %b want 1", full); end
      checks++; if (ovf_cnt != o0)      begin errors++; $display("FAIL ovf_early: got %0d pulses want 0", ovf_cnt - o0); end
      send_frame(exp[4], 1'b0, 1'b0, 1'b1, 0);
      checks++; if (ovf_cnt - o0 != 1)  begin errors++; $display("FAIL ovf_pulse: got %0d pulses want 1", ovf_cnt - o0); end
      checks++; if (count !== 3'd4)     begin errors++; $display("FAIL ovf_count: got %0d want 4", count); end
      // push and pop in the same cycle while full
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1);
      checks++; if (ovf_cnt - o0 != 1)  begin errors++; $display("FAIL pushpop_ovf: got %0d pulses want 1", ovf_cnt - o0); end
      checks++; if (count !== 3'd4)     begin errors++; $display("FAIL pushpop_count: got %0d want 4", count); end
      exp[0] = 8'h22; exp[1] = 8'h44; exp[2] = 8'h88; exp[3] = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         checks++; if (dout !== exp[i]) begin errors++; $display("FAIL ovf_dout%0d: got %h want %h", i, dout, exp[i]); end
         pop();
      end
      checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL ovf_drain_empty: got %b want 1", empty); end
   endtask

   task automatic test_timeout();
      logic [10:0] fr;
      int f0, n;
      f0 = ferr_cnt;
      fr = {1'b1, ~(^8'h55), 8'h55, 1'b0};
      for (int i = 0; i < 4; i++) send_bit(fr[i]);
      ps2data = fr[4];
      repeat (HALF) step();
      ps2clk = 1'b0;
      n = 0;
      while (n < TMO + 100) begin
         step();
         n++;
         if (n == HALF) ps2clk = 1'b1;
         if (frame_err) break;
      end
      checks++; if (n != TMO + EDGE_LAT) begin errors++; $display("FAIL timeout_cycle: got %0d want %0d", n, TMO + EDGE_LAT); end
      repeat (HALF) step();
      checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", ferr_cnt - f0); end
      checks++; if (count !== 3'd0)     begin errors++; $display("FAIL timeout_count: got %0d want 0", count); end
      send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 0);
      checks++; if (dout !== 8'h1C)     begin errors++; $display("FAIL timeout_next_dout: got %h want 1c", dout); end
      checks++; if (count !== 3'd1)     begin errors++; $display("FAIL timeout_next_count: got %0d want 1", count); end
      pop();
   endtask

   task automatic test_glitch();
      int f0;
      f0 = ferr_cnt;
      send_frame(8'hA7, 1'b0, 1'b0, 1'b1, 3);
      checks++; if (dout !== 8'hA7)  begin errors++; $display("FAIL glitch_dout: got %h want a7", dout); end
      checks++; if (count !== 3'd1)  begin errors++; $display("FAIL glitch_count: got %0d want 1", count); end
      checks++; if (ferr_cnt != f0)  begin errors++; $display("FAIL glitch_ferr: got %0d pulses want 0", ferr_cnt - f0); end
      pop();
   endtask

   task automatic test_rx_en();
      rx_en = 1'b0;
      send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 0);
      checks++; if (count !== 3'd0)  begin errors++; $display("FAIL rxen_blocked_count: got %0d want 0", count); end
      rx_en = 1'b1;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 4);
      checks++; if (dout !== 8'h3C)  begin errors++; $display("FAIL rxen_midframe_dout: got %h want 3c", dout); end
      checks++; if (count !== 3'd1)  begin errors++; $display("FAIL rxen_midframe_count: got %0d want 1", count); end
      rx_en = 1'b1;
      pop();
   endtask

   task automatic test_reset_mid_frame();
      logic [10:0] fr;
      int f0;
      fr = {1'b1, ~(^8'hE1), 8'hE1, 1'b0};
      for (int i = 0; i < 5; i++) send_bit(fr[i]);
      apply_reset();
      f0 = ferr_cnt;
      send_frame(8'h32, 1'b0, 1'b0, 1'b1, 0);
      checks++; if (dout !== 8'h32)  begin errors++; $display("FAIL rstmid_dout: got %h want 32", dout); end
      checks++; if (count !== 3'd1)  begin errors++; $display("FAIL rstmid_count: got %0d want 1", count); end
      checks++; if (ferr_cnt != f0)  begin errors++; $display("FAIL rstmid_ferr: got %0d pulses want 0", ferr_cnt - f0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_errors();
      test_overflow();
      test_timeout();
      test_glitch();
      test_rx_en();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
